// File: rtl/transpose_op_scheduler.sv
// Round-robin scheduler sharing one matrix transpose unit among NUM_REQ requesters.
// Issues a start pulse, waits for done under a watchdog, and returns done/err to the winner.
module transpose_op_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int SEL_W          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic               sched_busy,
    output logic               tu_start,
    input  logic               tu_busy,
    input  logic               tu_done
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [WD_W-1:0]    wd_cnt, wd_nxt;
    logic               ok_nxt;

    logic [SEL_W-1:0]   pick;
    logic               found;

    logic [NUM_REQ-1:0] grant_nxt, done_nxt, err_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               busy_nxt, start_nxt;

    // Scan downward so the last hit is the first set bit at or above ptr (mod NUM_REQ).
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            wd_cnt     <= '0;
            grant      <= '0;
            sel        <= '0;
            done       <= '0;
            err        <= '0;
            sched_busy <= 1'b0;
            tu_start   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            wd_cnt     <= wd_nxt;
            grant      <= grant_nxt;
            sel        <= sel_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            sched_busy <= busy_nxt;
            tu_start   <= start_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wd_nxt    = wd_cnt;
        ok_nxt    = 1'b0;
        case (state)
            IDLE: if (!tu_busy && found) state_nxt = START;
            START: begin
                wd_nxt    = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // tu_done takes priority over a coincident watchdog expiry
                if (tu_done) begin
                    state_nxt = DONE;
                    ok_nxt    = 1'b1;
                end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = DONE;
                end else begin
                    wd_nxt = wd_cnt + WD_W'(1);
                end
            end
            DONE: begin
                ptr_nxt   = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are the next-cycle values of the registered output flops.
    always_comb begin
        grant_nxt = grant;
        sel_nxt   = sel;
        done_nxt  = '0;
        err_nxt   = '0;
        if (state == IDLE && state_nxt == START) begin
            grant_nxt = NUM_REQ'(1) << pick;
            sel_nxt   = pick;
        end
        if (state == DONE) grant_nxt = '0;
        if (state == WAIT && state_nxt == DONE) begin
            if (ok_nxt) done_nxt = grant;
            else        err_nxt  = grant;
        end
        start_nxt = (state_nxt == START);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_transpose_op_scheduler.sv
// Directed bench for transpose_op_scheduler: reset, single op, round-robin, watchdog,
// done/timeout coincidence, busy blocking with pointer wrap, and reset mid-operation.
module tb_transpose_op_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] grant, done, err;
    logic [1:0]   sel;
    logic         sched_busy, tu_start, tu_busy, tu_done;

    int checks = 0;
    int errors = 0;
    int n_start = 0, n_done = 0, n_err = 0;

    transpose_op_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .sel(sel),
        .done(done), .err(err), .sched_busy(sched_busy), .tu_start(tu_start),
        .tu_busy(tu_busy), .tu_done(tu_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tu_start) n_start++;
        if (|done)    n_done++;
        if (|err)     n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!tu_start && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_start_seen"}, 32'(tu_start), 32'd1);
    endtask

    // Called in the START cycle; tu_done goes high 'lat' cycles after it.
    task automatic do_op(input int lat);
        for (int i = 0; i < lat; i++) begin
            step();
            if (i == 0) chk("start_one_cycle", 32'(tu_start), 32'd0);
        end
        tu_done = 1'b1;
        step();
        tu_done = 1'b0;
    endtask

    initial begin
        int s0, d0, e0, n;
        rst_n = 1'b0; req = '0; tu_busy = 1'b0; tu_done = 1'b0;
        step(); step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_sel",   32'(sel), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_start", 32'(tu_start), 0);
        chk("rst_busy",  32'(sched_busy), 0);
        rst_n = 1'b1;
        step();

        // round-robin with all requesters pending
        s0 = n_start;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_start("rr");
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            chk("rr_sel",   32'(sel), 32'(k % 4));
            do_op(1);
            chk("rr_done",  32'(done), 32'(4'b0001 << (k % 4)));
        end
        req = '0;
        step(); step();
        chk("rr_start_count", 32'(n_start - s0), 32'd8);

        // single request, unit answers 3 cycles after start
        s0 = n_start; d0 = n_done;
        req = 4'b0100;
        wait_start("single");
        chk("single_grant", 32'(grant), 32'b0100);
        chk("single_sel",   32'(sel), 32'd2);
        chk("single_busy",  32'(sched_busy), 32'd1);
        do_op(3);
        chk("single_done",  32'(done), 32'b0100);
        chk("single_err",   32'(err), 32'd0);
        req = '0;
        step();
        chk("single_done_pulse", 32'(done), 32'd0);
        chk("single_grant_clr",  32'(grant), 32'd0);
        chk("single_start_count", 32'(n_start - s0), 32'd1);
        chk("single_done_count",  32'(n_done - d0), 32'd1);

        // watchdog: ptr=3, so req[1] is found after wrapping
        req = 4'b0010;
        wait_start("wd");
        chk("wd_grant", 32'(grant), 32'b0010);
        n = 0;
        while (!(|err) && !(|done) && n < 40) begin
            step();
            n++;
        end
        chk("wd_err",   32'(err), 32'b0010);
        chk("wd_done",  32'(done), 32'd0);
        chk("wd_delay", 32'(n), 32'(TO + 1));
        req = '0;
        d0 = n_done;
        for (int i = 0; i < 5; i++) step();
        tu_done = 1'b1;
        step();
        tu_done = 1'b0;
        step(); step();
        chk("wd_late_no_done", 32'(n_done - d0), 32'd0);
        chk("wd_late_idle",    32'(sched_busy), 32'd0);

        // next request is served normally (ptr=2 -> requester 0)
        req = 4'b0001;
        wait_start("post_wd");
        chk("post_wd_grant", 32'(grant), 32'b0001);
        do_op(2);
        chk("post_wd_done", 32'(done), 32'b0001);
        req = '0;
        step();

        // tu_done on the last WAIT cycle beats the watchdog
        req = 4'b1000;
        wait_start("coinc");
        e0 = n_err;
        do_op(TO);
        chk("coinc_done", 32'(done), 32'b1000);
        chk("coinc_err",  32'(err), 32'd0);
        req = '0;
        step();
        chk("coinc_err_count", 32'(n_err - e0), 32'd0);

        // busy blocking, then wrap of ptr after requester 3
        tu_busy = 1'b1;
        req = 4'b1000;
        for (int i = 0; i < 5; i++) step();
        chk("busy_no_grant", 32'(grant), 32'd0);
        chk("busy_idle",     32'(sched_busy), 32'd0);
        tu_busy = 1'b0;
        wait_start("busy");
        chk("busy_grant", 32'(grant), 32'b1000);
        chk("busy_sel",   32'(sel), 32'd3);
        do_op(1);
        chk("busy_done", 32'(done), 32'b1000);
        req = 4'b1001;
        wait_start("wrap0");
        chk("wrap_grant0", 32'(grant), 32'b0001);
        do_op(1);
        chk("wrap_done0", 32'(done), 32'b0001);
        req = 4'b1000;
        wait_start("wrap3");
        chk("wrap_grant3", 32'(grant), 32'b1000);
        do_op(1);
        chk("wrap_done3", 32'(done), 32'b1000);
        req = '0;
        step();

        // asynchronous reset in the middle of WAIT
        req = 4'b0010;
        wait_start("mid");
        step(); step();
        d0 = n_done; e0 = n_err;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_sel",   32'(sel), 0);
        chk("mid_rst_busy",  32'(sched_busy), 0);
        chk("mid_rst_start", 32'(tu_start), 0);
        chk("mid_rst_de",    32'({done, err}), 0);
        req = '0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_busy", 32'(sched_busy), 0);
        chk("post_rst_done", 32'(n_done - d0), 0);
        chk("post_rst_err",  32'(n_err - e0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
